// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receiver, uart_rx_ctrl and the CPU-side consumer.
// rx_timeout exists only when UART_RX_CTRL_TIMEOUT_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int DataBits     = 8,
  parameter int FifoDepth    = 16,
  parameter int ErrCountBits = 8
);
  localparam int LevelBits = $clog2(FifoDepth) + 1;

  logic [DataBits-1:0]     rx_data;
  logic                    rx_valid;
  logic                    rx_break;
  logic                    rx_error;
  logic [DataBits-1:0]     m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [LevelBits-1:0]    fifo_level;
  logic                    overrun;
  logic                    break_active;
  logic [ErrCountBits-1:0] err_count;
  logic                    clear;
  logic                    flush;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic                    rx_timeout;
`endif

  // Receiver and consumer side.
  modport master (
`ifdef UART_RX_CTRL_TIMEOUT_EN
    input  rx_timeout,
`endif
    output rx_data, rx_valid, rx_break, rx_error, m_ready, clear, flush,
    input  m_data, m_valid, fifo_level, overrun, break_active, err_count
  );

  // The controller itself.
  modport slave (
`ifdef UART_RX_CTRL_TIMEOUT_EN
    output rx_timeout,
`endif
    input  rx_data, rx_valid, rx_break, rx_error, m_ready, clear, flush,
    output m_data, m_valid, fifo_level, overrun, break_active, err_count
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, overrun/break/error status, show-ahead stream.
// Optional stall timeout enabled by defining UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int DataBits     = 8,
  parameter int FifoDepth    = 16,
  parameter int ErrCountBits = 8
`ifdef UART_RX_CTRL_TIMEOUT_EN
  , parameter int TimeoutCycles = 1024
`endif
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.slave bus
);
  localparam int PtrBits   = $clog2(FifoDepth);
  localparam int LevelBits = PtrBits + 1;

  typedef enum logic {
    ST_RUN,
    ST_BREAK_HOLD
  } state_e;

  state_e                  state_q, state_d;
  logic [DataBits-1:0]     mem_q [FifoDepth];
  logic [PtrBits-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelBits-1:0]    level_q, level_d;
  logic                    overrun_q, overrun_d;
  logic [ErrCountBits-1:0] err_cnt_q, err_cnt_d;
  logic                    empty, full, pop, push, drop, err_evt;

  assign empty = (level_q == '0);
  assign full  = (level_q == LevelBits'(FifoDepth));
  assign pop   = !empty && bus.m_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:        if (bus.rx_break) state_d = ST_BREAK_HOLD;
      ST_BREAK_HOLD: if (bus.rx_valid) state_d = ST_RUN;
      default:       state_d = ST_RUN;
    endcase
  end

  always_comb begin
    bus.break_active = (state_q == ST_BREAK_HOLD);
    err_evt          = (state_q == ST_RUN) && bus.rx_error;
  end

  // The byte that ends a break is pushed under the ordinary rules.
  always_comb begin
    push     = 1'b0;
    drop     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      push = bus.rx_valid && (!full || pop);
      drop = bus.rx_valid && full && !pop;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end
  end

  // A same-cycle event overrides clear, so clear+error leaves a count of one.
  always_comb begin
    overrun_d = overrun_q;
    err_cnt_d = err_cnt_q;
    if (bus.clear) begin
      overrun_d = 1'b0;
      err_cnt_d = '0;
    end
    if (drop) overrun_d = 1'b1;
    if (err_evt && (err_cnt_d != '1)) err_cnt_d = err_cnt_d + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // NOTE: storage is not reset; the level counter guards it and m_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.m_valid    = !empty;
  assign bus.m_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.fifo_level = level_q;
  assign bus.overrun    = overrun_q;
  assign bus.err_count  = err_cnt_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int ToBits = $clog2(TimeoutCycles + 1);

  logic [ToBits-1:0] to_cnt_q, to_cnt_d;
  logic              to_q, to_d;

  // Counts only while bytes sit unread; any FIFO activity restarts the window.
  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    to_d     = 1'b0;
    if (push || pop || bus.flush || empty) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == ToBits'(TimeoutCycles - 1)) begin
      to_cnt_d = '0;
      to_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end

  assign bus.rx_timeout = to_q;
`endif
endmodule
